// File: rtl/controlador_display_multiplexado.sv
// Scan controller that time-multiplexes NUM_DIGITOS common-anode digits onto one shared
// BCD->7-segment decoder, with blanking gaps, leading-zero blanking and a double-buffered load port.
module controlador_display_multiplexado #(
    parameter int NUM_DIGITOS    = 4,
    parameter int CICLOS_DIGITO  = 50000,
    parameter int CICLOS_APAGADO = 500
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic                         i_Habilitar,
    input  logic                         i_Supr_Ceros,
    input  logic [4*NUM_DIGITOS-1:0]     i_Dato,
    input  logic                         i_Cargar,
    output logic                         o_Listo,
    output logic [3:0]                   o_Bcd,
    output logic [NUM_DIGITOS-1:0]       o_Anodos,
    output logic [$clog2(NUM_DIGITOS)-1:0] o_Digito_Idx,
    output logic                         o_Fin_Trama
);

    localparam int DATO_W     = 4 * NUM_DIGITOS;
    localparam int IDX_W      = $clog2(NUM_DIGITOS);
    localparam int CICLOS_MAX = (CICLOS_DIGITO > CICLOS_APAGADO) ? CICLOS_DIGITO : CICLOS_APAGADO;
    localparam int CNT_W      = (CICLOS_MAX > 1) ? $clog2(CICLOS_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_DIG_FIN = CNT_W'(CICLOS_DIGITO - 1);
    localparam logic [CNT_W-1:0] CNT_APG_FIN = CNT_W'(CICLOS_APAGADO - 1);
    localparam logic [IDX_W-1:0] IDX_ULTIMO  = IDX_W'(NUM_DIGITOS - 1);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        ENCENDIDO = 2'd1,
        APAGADO   = 2'd2
    } estado_t;

    estado_t                r_estado, w_estado;
    logic [IDX_W-1:0]       r_idx, w_idx;
    logic [CNT_W-1:0]       r_cnt, w_cnt;
    logic [DATO_W-1:0]      r_disp, w_disp;
    logic [DATO_W-1:0]      r_pend, w_pend;
    logic                   r_listo, w_listo;
    logic [NUM_DIGITOS-1:0] r_anodos, w_anodos;
    logic [3:0]             r_bcd, w_bcd;
    logic                   r_fin, w_fin;

    logic                   w_entrar;
    logic                   w_frontera;
    logic                   w_transferir;
    logic                   w_aceptar;
    logic [NUM_DIGITOS-1:0] w_blanco;

    // The pending flag is the inverse of o_Listo, so one register serves both.
    assign w_aceptar    = i_Cargar & r_listo;
    assign w_transferir = ~r_listo & ((r_estado == REPOSO) | w_frontera);
    assign w_disp       = w_transferir ? r_pend : r_disp;
    assign w_pend       = w_aceptar ? i_Dato : r_pend;

    always_comb begin
        w_listo = r_listo;
        if (w_aceptar) begin
            w_listo = 1'b0;
        end else if (w_transferir) begin
            w_listo = 1'b1;
        end
    end

    // Blank mask is built from the data about to be shown, so a new frame blanks with its own data.
    always_comb begin : blanqueo
        logic ceros_arriba;
        ceros_arriba = 1'b1;
        w_blanco     = '0;
        for (int k = NUM_DIGITOS - 1; k >= 0; k--) begin
            ceros_arriba = ceros_arriba & (w_disp[4*k +: 4] == 4'd0);
            w_blanco[k]  = i_Supr_Ceros & (k != 0) & ceros_arriba;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        w_estado   = r_estado;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_anodos   = r_anodos;
        w_bcd      = r_bcd;
        w_fin      = 1'b0;
        w_entrar   = 1'b0;
        w_frontera = 1'b0;

        if (!i_Habilitar) begin
            w_estado = REPOSO;
            w_idx    = '0;
            w_cnt    = '0;
            w_anodos = '1;
        end else begin
            case (r_estado)
                REPOSO: begin
                    w_estado = ENCENDIDO;
                    w_idx    = '0;
                    w_cnt    = '0;
                    w_entrar = 1'b1;
                end
                ENCENDIDO: begin
                    if (r_cnt == CNT_DIG_FIN) begin
                        w_estado = APAGADO;
                        w_cnt    = '0;
                        w_anodos = '1;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                APAGADO: begin
                    if (r_cnt == CNT_APG_FIN) begin
                        w_estado = ENCENDIDO;
                        w_cnt    = '0;
                        w_entrar = 1'b1;
                        if (r_idx == IDX_ULTIMO) begin
                            w_idx      = '0;
                            w_frontera = 1'b1;
                            w_fin      = 1'b1;
                        end else begin
                            w_idx = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_estado = REPOSO;
                    w_idx    = '0;
                    w_cnt    = '0;
                    w_anodos = '1;
                end
            endcase

            if (w_entrar) begin
                w_bcd    = w_disp[4*int'(w_idx) +: 4];
                w_anodos = '1;
                if (!w_blanco[w_idx]) begin
                    w_anodos[w_idx] = 1'b0;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only; the display and pending
    // buffers are reset too, because a blank display after reset is part of the behaviour.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_estado <= REPOSO;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_disp   <= '0;
            r_pend   <= '0;
            r_listo  <= 1'b1;
            r_anodos <= '1;
            r_bcd    <= 4'd0;
            r_fin    <= 1'b0;
        end else begin
            r_estado <= w_estado;
            r_idx    <= w_idx;
            r_cnt    <= w_cnt;
            r_disp   <= w_disp;
            r_pend   <= w_pend;
            r_listo  <= w_listo;
            r_anodos <= w_anodos;
            r_bcd    <= w_bcd;
            r_fin    <= w_fin;
        end
    end

    assign o_Listo      = r_listo;
    assign o_Bcd        = r_bcd;
    assign o_Anodos     = r_anodos;
    assign o_Digito_Idx = r_idx;
    assign o_Fin_Trama  = r_fin;

endmodule
